// File: rtl/exec_unit_scheduler.sv
// exec_unit_scheduler: issue/writeback controller for the INT, FP and SQRT execution units.
// Build option: define SCOREBOARD_EN to add a pending-register mask that stalls RAW/WAW hazards.
module exec_unit_scheduler #(
    parameter int DATA_W   = 32,
    parameter int INT_LAT  = 1,
    parameter int FP_LAT   = 4,
    parameter int SQRT_LAT = 16,
    parameter int LAT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [1:0]        issue_unit,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        issue_rs,
    input  logic [4:0]        issue_rt,
    output logic [2:0]        unit_start,
    input  logic [DATA_W-1:0] int_result,
    input  logic [DATA_W-1:0] fp_result,
    input  logic [DATA_W-1:0] sqrt_result,
    output logic [2:0]        unit_busy,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal_op
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    localparam int NU = 3;
    localparam int LAT [NU] = '{INT_LAT, FP_LAT, SQRT_LAT};

    state_t              st     [NU];
    state_t              st_nx  [NU];
    logic [LAT_W-1:0]    cnt    [NU];
    logic [LAT_W-1:0]    cnt_nx [NU];
    logic [4:0]          rd_q   [NU];
    logic [DATA_W-1:0]   hold   [NU];
    logic [DATA_W-1:0]   res    [NU];
    logic [NU-1:0]       cap;
    logic [NU-1:0]       idle;
    logic [NU-1:0]       req;
    logic [NU-1:0]       gnt;
    logic [3:0]          idle_x;
    logic                legal;
    logic                hazard;
    logic                fire;

    assign res[0] = int_result;
    assign res[1] = fp_result;
    assign res[2] = sqrt_result;

`ifdef SCOREBOARD_EN
    logic [31:0] pending;

    assign hazard = pending[issue_rs] | pending[issue_rt] | pending[issue_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (wb_valid)
                pending[wb_rd] <= 1'b0;
            if (fire && legal && issue_rd != 5'd0)
                pending[issue_rd] <= 1'b1;
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{issue_rs, issue_rt};
    assign hazard     = 1'b0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NU; i++) begin
            idle[i]      = (st[i] == S_IDLE);
            req[i]       = (st[i] == S_WB) && !reset;
            unit_busy[i] = (st[i] != S_IDLE);
        end
    end

    assign idle_x      = {1'b0, idle};
    assign legal       = (issue_unit != 2'd3);
    assign issue_ready = !legal || (idle_x[issue_unit] && !hazard);
    assign fire        = issue_valid && issue_ready && !reset;

    always_comb begin
        for (int unsigned i = 0; i < NU; i++)
            unit_start[i] = fire && legal && (issue_unit == 2'(i));
    end

    always_comb begin
        gnt = '0;
        if (req[2])      gnt = 3'b100;
        else if (req[1]) gnt = 3'b010;
        else if (req[0]) gnt = 3'b001;
        wb_valid = |gnt;
        wb_rd    = '0;
        wb_data  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (gnt[i]) begin
                wb_rd   = rd_q[i];
                wb_data = hold[i];
            end
        end
    end

    // The fire cycle counts as the first execution cycle, so the result is
    // captured on the edge ending cycle t+LAT-1 (a latency-1 unit captures on the fire edge).
    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        cap    = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            case (st[i])
                S_IDLE: begin
                    if (unit_start[i]) begin
                        if (LAT[i] <= 1) begin
                            cap[i]   = 1'b1;
                            st_nx[i] = S_WB;
                        end else begin
                            cnt_nx[i] = LAT_W'(LAT[i] - 2);
                            st_nx[i]  = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt[i] == '0) begin
                        cap[i]   = 1'b1;
                        st_nx[i] = S_WB;
                    end else begin
                        cnt_nx[i] = cnt[i] - 1'b1;
                    end
                end
                S_WB: begin
                    if (gnt[i])
                        st_nx[i] = S_IDLE;
                end
                default: st_nx[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NU; i++) begin
                st[i]   <= S_IDLE;
                cnt[i]  <= '0;
                rd_q[i] <= '0;
                hold[i] <= '0;
            end
            illegal_op <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NU; i++) begin
                st[i]  <= st_nx[i];
                cnt[i] <= cnt_nx[i];
                if (unit_start[i])
                    rd_q[i] <= issue_rd;
                if (cap[i])
                    hold[i] <= res[i];
            end
            illegal_op <= fire && !legal;
        end
    end

endmodule

// File: tb/tb_exec_unit_scheduler.sv
// Testbench for exec_unit_scheduler: directed vector table, hand-written corner sequences
// and a randomized run checked against a cycle-arithmetic reference model.
module tb_exec_unit_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_unit;
    logic [4:0]  issue_rd, issue_rs, issue_rt;
    logic [2:0]  unit_start;
    logic [31:0] int_result, fp_result, sqrt_result;
    logic [2:0]  unit_busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    exec_unit_scheduler #(
        .DATA_W(32), .INT_LAT(1), .FP_LAT(4), .SQRT_LAT(16), .LAT_W(5)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
        .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .unit_start(unit_start),
        .int_result(int_result), .fp_result(fp_result), .sqrt_result(sqrt_result),
        .unit_busy(unit_busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input int u);
        case (u)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] u, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        issue_valid = v;
        issue_unit  = u;
        issue_rd    = rd;
        issue_rs    = rs;
        issue_rt    = rt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  unit;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  exp_start;
        int          exp_lat;
        logic        exp_ill;
    } vec_t;

    vec_t tv [5];

    // reference model state
    logic        m_inflight [3];
    int          m_done     [3];
    logic [4:0]  m_rd       [3];
    logic [31:0] m_data     [3];
    logic        m_prev_ill;
    logic [31:0] m_pend;

    initial begin
        int_result  = '0;
        fp_result   = '0;
        sqrt_result = '0;
        do_reset();

        // reset / idle state
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'(k), 5'd1, 5'd2, 5'd3);
            #2;
            chk("idle_ready", issue_ready, 1'b1);
            chk("idle_busy", unit_busy, 3'b000);
            chk("idle_wb_valid", wb_valid, 1'b0);
            chk("idle_wb_rd", wb_rd, 5'd0);
            chk("idle_wb_data", wb_data, 32'd0);
            chk("idle_illegal", illegal_op, 1'b0);
            chk("idle_start", unit_start, 3'b000);
            tick();
        end

        // single-op vector table
        tv[0] = '{unit: 2'd0, rd: 5'd3,  data: 32'h11111111, exp_start: 3'b001, exp_lat: 1,  exp_ill: 1'b0};
        tv[1] = '{unit: 2'd1, rd: 5'd5,  data: 32'h3F800000, exp_start: 3'b010, exp_lat: 4,  exp_ill: 1'b0};
        tv[2] = '{unit: 2'd2, rd: 5'd9,  data: 32'h40490FDB, exp_start: 3'b100, exp_lat: 16, exp_ill: 1'b0};
        tv[3] = '{unit: 2'd0, rd: 5'd0,  data: 32'hDEADBEEF, exp_start: 3'b001, exp_lat: 1,  exp_ill: 1'b0};
        tv[4] = '{unit: 2'd3, rd: 5'd7,  data: 32'h12345678, exp_start: 3'b000, exp_lat: 0,  exp_ill: 1'b1};
        for (int n = 0; n < 5; n++) begin
            do_reset();
            for (int k = 0; k <= 18; k++) begin
                if (k == 0) begin
                    drive(1'b1, tv[n].unit, tv[n].rd, 5'd0, 5'd0);
                end else begin
                    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
                end
                if (tv[n].exp_lat == 0 || k < tv[n].exp_lat) begin
                    int_result  = (tv[n].unit == 2'd0) ? tv[n].data : ~tv[n].data;
                    fp_result   = (tv[n].unit == 2'd1) ? tv[n].data : ~tv[n].data;
                    sqrt_result = (tv[n].unit == 2'd2) ? tv[n].data : ~tv[n].data;
                end else begin
                    int_result  = 32'hBAD00000 ^ 32'(k);
                    fp_result   = 32'hBAD10000 ^ 32'(k);
                    sqrt_result = 32'hBAD20000 ^ 32'(k);
                end
                #2;
                if (k == 0) begin
                    chk("vec_ready", issue_ready, 1'b1);
                    chk("vec_start", unit_start, tv[n].exp_start);
                end
                if (k == 1) chk("vec_illegal", illegal_op, tv[n].exp_ill);
                if (k == 2) chk("vec_illegal_clear", illegal_op, 1'b0);
                chk("vec_busy", unit_busy,
                    (k >= 1 && k <= tv[n].exp_lat) ? tv[n].exp_start : 3'b000);
                chk("vec_wb_valid", wb_valid, (tv[n].exp_lat > 0 && k == tv[n].exp_lat));
                if (tv[n].exp_lat > 0 && k == tv[n].exp_lat) begin
                    chk("vec_wb_rd", wb_rd, tv[n].rd);
                    chk("vec_wb_data", wb_data, tv[n].data);
                end
                tick();
            end
        end

        // SQRT at cycle 0, FP at cycle 12: both complete at 16, SQRT wins, FP follows
        do_reset();
        for (int k = 0; k <= 19; k++) begin
            if (k == 0)       drive(1'b1, 2'd2, 5'd10, 5'd0, 5'd0);
            else if (k == 12) drive(1'b1, 2'd1, 5'd11, 5'd0, 5'd0);
            else              drive(1'b0, 2'd1, 5'd0, 5'd0, 5'd0);
            sqrt_result = (k < 16) ? 32'hA5A5A5A5 : 32'h0BAD0BAD;
            fp_result   = (k < 16) ? 32'h3F800000 : 32'h0BADF00D;
            #2;
            if (k == 16) begin
                chk("coll_wb16_valid", wb_valid, 1'b1);
                chk("coll_wb16_rd", wb_rd, 5'd10);
                chk("coll_wb16_data", wb_data, 32'hA5A5A5A5);
                chk("coll_busy16", unit_busy, 3'b110);
                chk("coll_fp_ready16", issue_ready, 1'b0);
            end else if (k == 17) begin
                chk("coll_wb17_valid", wb_valid, 1'b1);
                chk("coll_wb17_rd", wb_rd, 5'd11);
                chk("coll_wb17_data", wb_data, 32'h3F800000);
                chk("coll_busy17", unit_busy, 3'b010);
            end else begin
                chk("coll_wb_quiet", wb_valid, 1'b0);
            end
            tick();
        end

        // INT held in WB behind FP: INT stalls until the cycle after its grant, SQRT still issues
        do_reset();
        for (int k = 0; k <= 7; k++) begin
            case (k)
                0:       drive(1'b1, 2'd1, 5'd4, 5'd0, 5'd0);
                3:       drive(1'b1, 2'd0, 5'd6, 5'd0, 5'd0);
                4:       drive(1'b1, 2'd0, 5'd12, 5'd0, 5'd0);
                5:       drive(1'b1, 2'd2, 5'd13, 5'd0, 5'd0);
                6:       drive(1'b1, 2'd0, 5'd14, 5'd0, 5'd0);
                default: drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
            endcase
            fp_result  = 32'h00000F00;
            int_result = (k <= 3) ? 32'h00000100 : 32'h00000999;
            #2;
            case (k)
                4: begin
                    chk("stall_int_ready4", issue_ready, 1'b0);
                    chk("stall_int_start4", unit_start, 3'b000);
                    chk("stall_wb4_rd", wb_rd, 5'd4);
                end
                5: begin
                    chk("stall_sqrt_ready5", issue_ready, 1'b1);
                    chk("stall_sqrt_start5", unit_start, 3'b100);
                    chk("stall_wb5_rd", wb_rd, 5'd6);
                    chk("stall_wb5_data", wb_data, 32'h00000100);
                end
                6: begin
                    chk("stall_int_ready6", issue_ready, 1'b1);
                    chk("stall_int_start6", unit_start, 3'b001);
                end
                default: ;
            endcase
            tick();
        end

        // reset during SQRT EXEC, with a competing fire while reset is high
        do_reset();
        drive(1'b1, 2'd2, 5'd20, 5'd0, 5'd0);
        #2;
        chk("rst_sqrt_start", unit_start, 3'b100);
        tick();
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        drive(1'b1, 2'd1, 5'd21, 5'd0, 5'd0);
        #2;
        chk("rst_fire_start", unit_start, 3'b000);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 24; k++) begin
            #2;
            chk("rst_no_wb", wb_valid, 1'b0);
            chk("rst_busy", unit_busy, 3'b000);
            tick();
        end

        // register hazard: FP rd=7 in flight, INT reading r7
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) drive(1'b1, 2'd1, 5'd7, 5'd0, 5'd0);
            else        drive(1'b1, 2'd0, 5'd8, 5'd7, 5'd0);
            #2;
            if (k >= 1) begin
`ifdef SCOREBOARD_EN
                chk("sb_int_ready", issue_ready, (k == 5));
                chk("sb_int_start", unit_start, (k == 5) ? 3'b001 : 3'b000);
`else
                chk("sb_int_ready", issue_ready, 1'b1);
                if (k == 1) chk("sb_int_start", unit_start, 3'b001);
`endif
            end
            if (k == 1) break;
`ifndef SCOREBOARD_EN
`else
`endif
            tick();
        end
        tick();

        // randomized run against the reference model
        do_reset();
        for (int u = 0; u < 3; u++) begin
            m_inflight[u] = 1'b0;
            m_done[u]     = 0;
            m_rd[u]       = '0;
            m_data[u]     = '0;
        end
        m_prev_ill = 1'b0;
        m_pend     = '0;
        for (int c = 0; c < 3000; c++) begin
            int          g;
            logic        e_ready, e_fire;
            logic [2:0]  e_start, e_busy;
            logic [31:0] rv [3];
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
                  5'($urandom), 5'($urandom), 5'($urandom));
            rv[0] = $urandom; rv[1] = $urandom; rv[2] = $urandom;
            int_result  = rv[0];
            fp_result   = rv[1];
            sqrt_result = rv[2];
            #2;
            chk("rnd_illegal", illegal_op, m_prev_ill);
            if (reset) begin
                chk("rnd_rst_start", unit_start, 3'b000);
                chk("rnd_rst_wb", wb_valid, 1'b0);
                for (int u = 0; u < 3; u++) m_inflight[u] = 1'b0;
                m_prev_ill = 1'b0;
                m_pend     = '0;
            end else begin
                g = -1;
                for (int u = 2; u >= 0; u--)
                    if (g < 0 && m_inflight[u] && m_done[u] <= c) g = u;
                for (int u = 0; u < 3; u++) e_busy[u] = m_inflight[u];
                if (issue_unit == 2'd3) begin
                    e_ready = 1'b1;
                end else begin
                    e_ready = !m_inflight[issue_unit];
`ifdef SCOREBOARD_EN
                    if (m_pend[issue_rs] || m_pend[issue_rt] || m_pend[issue_rd]) e_ready = 1'b0;
`endif
                end
                e_fire  = issue_valid && e_ready;
                e_start = (e_fire && issue_unit != 2'd3) ? (3'b001 << issue_unit) : 3'b000;
                chk("rnd_ready", issue_ready, e_ready);
                chk("rnd_start", unit_start, e_start);
                chk("rnd_busy", unit_busy, e_busy);
                chk("rnd_wb_valid", wb_valid, (g >= 0));
                chk("rnd_wb_rd", wb_rd, (g >= 0) ? m_rd[g] : 5'd0);
                chk("rnd_wb_data", wb_data, (g >= 0) ? m_data[g] : 32'd0);
                if (g >= 0) begin
                    m_inflight[g]  = 1'b0;
                    m_pend[m_rd[g]] = 1'b0;
                end
                m_prev_ill = e_fire && issue_unit == 2'd3;
                if (e_fire && issue_unit != 2'd3) begin
                    m_inflight[issue_unit] = 1'b1;
                    m_done[issue_unit]     = c + lat_of(int'(issue_unit));
                    m_rd[issue_unit]       = issue_rd;
                    if (issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
                end
                for (int u = 0; u < 3; u++)
                    if (m_inflight[u] && m_done[u] - 1 == c) m_data[u] = rv[u];
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
